// File: rtl/reg_file_sb.sv
// reg_file_sb: parameterised register file with a hardwired zero register and
// an optional flag register. Both read ports bypass the same-cycle writeback.
// It also has a busy scoreboard for read-after-write hazard detection and a
// registered debug peek port.
module reg_file_sb #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter bit FLAG_EN  = 1'b1,
  parameter int FLAG_REG = 8,
  localparam int N       = 1 << ADDR_W
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              RegWre,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] Rs,
  input  logic [ADDR_W-1:0] Rt,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  input  logic              IssueValid,
  input  logic [ADDR_W-1:0] IssueReg,
  output logic              Hazard,
  output logic [N-1:0]      BusyMask,
  input  logic [ADDR_W-1:0] PeekAddr,
  output logic [DATA_W-1:0] RegPeek
);

  localparam logic [ADDR_W-1:0] FLAG_A = ADDR_W'(FLAG_REG);

  logic [N-1:0][DATA_W-1:0] regs_q;
  logic [N-1:0]             busy_q, busy_d;
  logic [DATA_W-1:0]        peek_q;
  logic [DATA_W-1:0]        wv;
  logic                     wr_en;
  logic                     hz1, hz2;

  // Effective write value: the flag register stores a zero-test of the data.
  always_comb begin
    wv = WriteData;
    if (FLAG_EN && (WriteReg == FLAG_A))
      wv = {{(DATA_W-1){1'b0}}, (WriteData == '0)};
  end

  // A write to register 0 is dropped, so that register stays zero.
  assign wr_en = RegWre && (WriteReg != '0);

  // Register array update. Reset takes priority over any write.
  always_ff @(posedge Clk) begin
    if (Rst)        regs_q <= '0;
    else if (wr_en) regs_q[WriteReg] <= wv;
  end

  // Read ports: register 0 reads zero, and a same-cycle writeback is forwarded.
  always_comb begin
    ReadData1 = regs_q[Rs];
    if (Rs == '0)                         ReadData1 = '0;
    else if (RegWre && (WriteReg == Rs)) ReadData1 = wv;
  end

  // Second read port, with the same priority as the first.
  always_comb begin
    ReadData2 = regs_q[Rt];
    if (Rt == '0)                         ReadData2 = '0;
    else if (RegWre && (WriteReg == Rt)) ReadData2 = wv;
  end

  // Scoreboard next state. A new issue beats a same-cycle write to the same register.
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < N; i++) begin
      if (IssueValid && (IssueReg == ADDR_W'(i)))  busy_d[i] = 1'b1;
      else if (RegWre && (WriteReg == ADDR_W'(i))) busy_d[i] = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  // Scoreboard state. Reset discards any pending producers.
  always_ff @(posedge Clk) begin
    if (Rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  // Hazard logic. A write landing this cycle clears the wait through the bypass.
  assign hz1 = (Rs != '0) && busy_q[Rs] && !(RegWre && (WriteReg == Rs));
  assign hz2 = (Rt != '0) && busy_q[Rt] && !(RegWre && (WriteReg == Rt));
  assign Hazard   = hz1 || hz2;
  assign BusyMask = busy_q;

  // Debug peek samples the array before any write lands (no bypass). Register 0 is always zero.
  always_ff @(posedge Clk) begin
    if (Rst) peek_q <= '0;
    else     peek_q <= regs_q[PeekAddr];
  end

  assign RegPeek = peek_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb. It drives the default configuration, checks it every
// cycle against a behavioural model, and adds directed literal checks. Two
// more instances cover FLAG_EN=0 and a 32-bit data / 5-bit address build.
module tb_reg_file_sb;
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  logic        Rst = 1'b1;
  logic        RegWre = 0, IssueValid = 0;
  logic [3:0]  WriteReg = 0, Rs = 0, Rt = 0, IssueReg = 0, PeekAddr = 0;
  logic [15:0] WriteData = 0, ReadData1, ReadData2, RegPeek, BusyMask;
  logic        Hazard;

  reg_file_sb #(.DATA_W(16), .ADDR_W(4), .FLAG_EN(1'b1), .FLAG_REG(8)) dut (
    .Clk(Clk), .Rst(Rst), .RegWre(RegWre), .WriteReg(WriteReg), .WriteData(WriteData),
    .Rs(Rs), .Rt(Rt), .ReadData1(ReadData1), .ReadData2(ReadData2),
    .IssueValid(IssueValid), .IssueReg(IssueReg), .Hazard(Hazard), .BusyMask(BusyMask),
    .PeekAddr(PeekAddr), .RegPeek(RegPeek));

  // FLAG_EN=0 instance
  logic        nf_we = 0;
  logic [3:0]  nf_wr = 0, nf_rs = 0;
  logic [15:0] nf_wd = 0, nf_rd1, nf_rd2, nf_peek, nf_busy;
  logic        nf_hz;
  reg_file_sb #(.DATA_W(16), .ADDR_W(4), .FLAG_EN(1'b0), .FLAG_REG(8)) dut_nf (
    .Clk(Clk), .Rst(Rst), .RegWre(nf_we), .WriteReg(nf_wr), .WriteData(nf_wd),
    .Rs(nf_rs), .Rt(4'd0), .ReadData1(nf_rd1), .ReadData2(nf_rd2),
    .IssueValid(1'b0), .IssueReg(4'd0), .Hazard(nf_hz), .BusyMask(nf_busy),
    .PeekAddr(4'd0), .RegPeek(nf_peek));

  // DATA_W=32, ADDR_W=5 instance
  logic        w_we = 0;
  logic [4:0]  w_wr = 0, w_rs = 0, w_pa = 0;
  logic [31:0] w_wd = 0, w_rd1, w_rd2, w_peek, w_busy;
  logic        w_hz;
  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .FLAG_EN(1'b1), .FLAG_REG(8)) dut_w (
    .Clk(Clk), .Rst(Rst), .RegWre(w_we), .WriteReg(w_wr), .WriteData(w_wd),
    .Rs(w_rs), .Rt(5'd0), .ReadData1(w_rd1), .ReadData2(w_rd2),
    .IssueValid(1'b0), .IssueReg(5'd0), .Hazard(w_hz), .BusyMask(w_busy),
    .PeekAddr(w_pa), .RegPeek(w_peek));

  // Behavioural model of the default instance
  logic [15:0] mregs [16];
  logic [15:0] mbusy = '0;
  logic [15:0] mpeek = '0;

  function automatic logic [15:0] m_wv();
    return (WriteReg == 4'd8) ? {15'd0, WriteData == 16'd0} : WriteData;
  endfunction

  function automatic logic [15:0] m_rd(input logic [3:0] a);
    if (a == 0) return 16'd0;
    if (RegWre && WriteReg == a) return m_wv();
    return mregs[a];
  endfunction

  function automatic logic m_hz(input logic [3:0] a);
    return (a != 0) && mbusy[a] && !(RegWre && WriteReg == a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state update on each rising edge
  always @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < 16; i++) mregs[i] = '0;
      mbusy = '0;
      mpeek = '0;
    end else begin
      logic [15:0] nb;
      nb = mbusy;
      mpeek = mregs[PeekAddr];
      if (RegWre && WriteReg != 0) mregs[WriteReg] = m_wv();
      if (RegWre) nb[WriteReg] = 1'b0;
      if (IssueValid) nb[IssueReg] = 1'b1;
      nb[0] = 1'b0;
      mbusy = nb;
    end
  end

  // Per-cycle compare against the model
  always @(negedge Clk) begin
    if (chk_en) begin
      chk("m_rd1",  {16'd0, ReadData1}, {16'd0, m_rd(Rs)});
      chk("m_rd2",  {16'd0, ReadData2}, {16'd0, m_rd(Rt)});
      chk("m_hz",   {31'd0, Hazard}, {31'd0, m_hz(Rs) | m_hz(Rt)});
      chk("m_busy", {16'd0, BusyMask}, {16'd0, mbusy});
      chk("m_peek", {16'd0, RegPeek}, {16'd0, mpeek});
    end
  end

  task automatic step();
    @(posedge Clk); #1;
  endtask

  task automatic idle();
    RegWre = 0; IssueValid = 0; WriteReg = 0; WriteData = 0; IssueReg = 0;
  endtask

  initial begin
    // 1: reset, then read every register
    step(); step();
    chk_en = 1'b1;
    Rst = 0;
    for (int a = 0; a < 16; a++) begin
      Rs = 4'(a); #0.1;
      chk("rst_rd", {16'd0, ReadData1}, 32'd0);
    end
    chk("rst_busy", {16'd0, BusyMask}, 32'd0);
    chk("rst_peek", {16'd0, RegPeek}, 32'd0);
    RegWre = 1; WriteReg = 5; WriteData = 16'hABCD; step();
    idle(); Rs = 5; #1;
    chk("r5_wr", {16'd0, ReadData1}, 32'hABCD);
    Rst = 1; step(); Rst = 0; #1;
    chk("r5_rst", {16'd0, ReadData1}, 32'd0);

    // 2: same-cycle bypass and the zero register
    RegWre = 1; WriteReg = 3; WriteData = 16'h1234; Rs = 3; Rt = 0; #1;
    chk("byp_rd1", {16'd0, ReadData1}, 32'h1234);
    chk("byp_rd2", {16'd0, ReadData2}, 32'd0);
    step(); idle(); #1;
    chk("r3_hold", {16'd0, ReadData1}, 32'h1234);
    RegWre = 1; WriteReg = 0; WriteData = 16'hFFFF; Rs = 0; #1;
    chk("r0_byp", {16'd0, ReadData1}, 32'd0);
    step(); idle(); #1;
    chk("r0_hold", {16'd0, ReadData1}, 32'd0);

    // 3: flag register, with and without the transform
    RegWre = 1; WriteReg = 8; WriteData = 16'h0000;
    nf_we = 1; nf_wr = 8; nf_wd = 16'h0000; step();
    idle(); nf_we = 0; Rs = 8; nf_rs = 8; #1;
    chk("flag_z", {16'd0, ReadData1}, 32'h0001);
    chk("nf_z",   {16'd0, nf_rd1}, 32'h0000);
    RegWre = 1; WriteReg = 8; WriteData = 16'h0042;
    nf_we = 1; nf_wr = 8; nf_wd = 16'h0042; #1;
    chk("flag_nz_byp", {16'd0, ReadData1}, 32'h0000);
    chk("nf_nz_byp",   {16'd0, nf_rd1}, 32'h0042);
    step(); idle(); nf_we = 0; #1;
    chk("flag_nz", {16'd0, ReadData1}, 32'h0000);
    chk("nf_nz",   {16'd0, nf_rd1}, 32'h0042);

    // 4: scoreboard hazard and how a write resolves it
    IssueValid = 1; IssueReg = 6; step();
    idle(); Rs = 6; Rt = 0; #1;
    chk("busy6", {31'd0, BusyMask[6]}, 32'd1);
    chk("hz6",   {31'd0, Hazard}, 32'd1);
    Rs = 0; Rt = 6; #1;
    chk("hz6_rt", {31'd0, Hazard}, 32'd1);
    IssueValid = 1; IssueReg = 6; step(); idle(); #1;
    chk("reissue", {16'd0, BusyMask}, 32'h0040);
    Rs = 6; Rt = 0; RegWre = 1; WriteReg = 6; WriteData = 16'h0777; #1;
    chk("hz6_wr",  {31'd0, Hazard}, 32'd0);
    chk("rd6_byp", {16'd0, ReadData1}, 32'h0777);
    step(); idle(); #1;
    chk("busy6_clr", {31'd0, BusyMask[6]}, 32'd0);
    chk("hz6_clr",   {31'd0, Hazard}, 32'd0);
    RegWre = 1; WriteReg = 4; WriteData = 16'h0004; step(); idle(); #1;
    chk("wr_nonbusy", {16'd0, BusyMask}, 32'h0000);

    // 5: issue and write in the same cycle, issue to register 0, reset clears pending
    IssueValid = 1; IssueReg = 9; RegWre = 1; WriteReg = 9; WriteData = 16'h0005; step();
    idle(); #1;
    chk("iw_same", {16'd0, BusyMask}, 32'h0200);
    IssueValid = 1; IssueReg = 0; step(); idle(); #1;
    chk("issue0", {16'd0, BusyMask}, 32'h0200);
    IssueValid = 1; IssueReg = 6; step(); idle(); #1;
    chk("busy240", {16'd0, BusyMask}, 32'h0240);
    Rst = 1; IssueValid = 1; IssueReg = 2; step(); Rst = 0; idle(); #1;
    chk("busy_rst", {16'd0, BusyMask}, 32'h0000);

    // Peek latency on the default instance
    PeekAddr = 7; RegWre = 1; WriteReg = 7; WriteData = 16'h5A5A; step(); idle(); #1;
    chk("peek_wcyc", {16'd0, RegPeek}, 32'h0000);
    step(); #1;
    chk("peek_lat", {16'd0, RegPeek}, 32'h5A5A);
    PeekAddr = 0; step(); #1;
    chk("peek_0", {16'd0, RegPeek}, 32'h0000);

    // 6: 32-bit / 5-bit address instance
    w_we = 1; w_wr = 31; w_wd = 32'hDEADBEEF; w_rs = 31; w_pa = 31; #1;
    chk("w_byp", w_rd1, 32'hDEADBEEF);
    step(); w_we = 0; #1;
    chk("w_peek_wcyc", w_peek, 32'h0);
    chk("w_rd31", w_rd1, 32'hDEADBEEF);
    step(); #1;
    chk("w_peek", w_peek, 32'hDEADBEEF);
    w_we = 1; w_wr = 8; w_wd = 32'h0; w_rs = 8; #1;
    chk("w_flag", w_rd1, 32'h1);
    step(); w_we = 0;

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
